cmd_fifo_iface: RTL and testbench
=================================

CMD_FIFO_IFACE -- requirements
Module: cmd_fifo_iface

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 5, log2 of FIFO depth in 32-bit words; DEPTH = 2^DEPTH_LOG2.
REQ-002 SHALL have parameter HI_WATER, default 24, high-watermark level in words.
REQ-003 SHALL have parameter LO_WATER, default 8, low-watermark level in words.
REQ-004 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port CPURead, input, 1: single-cycle register read strobe.
REQ-007 SHALL have port CPUWrite, input, 1: single-cycle register write strobe.
REQ-008 SHALL have port CPUAddress, input, 16: register byte address.
REQ-009 SHALL have port CPUWriteData, input, 32: write data, valid while CPUWrite is high.
REQ-010 SHALL have port CPUReadData, output, 32: read data, combinational from CPUAddress and valid in the CPURead cycle.
REQ-011 SHALL have port fifo_data, output, 32: FIFO head word.
REQ-012 SHALL have port fifo_valid, output, 1: head word available to the consumer.
REQ-013 SHALL have port fifo_ready, input, 1: consumer accepts; a pop occurs when fifo_valid and fifo_ready are both high.
REQ-014 SHALL have port irq, output, 1: level-sensitive watermark interrupt.

Function
REQ-015 Register map (CPUAddress): 0x0000 DATA, write-only, pushes; reads 0. 0x0004 STATUS, read-only. 0x0008 CONTROL, read/write. 0x000C CLEAR, write-1-to-clear; reads 0.
REQ-016 Any other address SHALL read 0, and writes to it SHALL have no effect.
REQ-017 STATUS layout: [DEPTH_LOG2:0] level; bit16 empty; bit17 full; bit18 overflow (sticky); bit19 hi_pend; bit20 lo_pend; all other bits 0.
REQ-018 CONTROL layout: bit0 out_en; bit1 hi_irq_en; bit2 lo_irq_en; other bits write-ignored and read 0.
REQ-019 CLEAR: bit0 clears overflow, bit1 clears hi_pend, bit2 clears lo_pend.
REQ-020 A CPUWrite to DATA in cycle N SHALL push CPUWriteData; the level SHALL increment at N+1, and fifo_valid SHALL rise at N+1 if out_en is set.
REQ-021 The FIFO SHALL be first-word-fall-through: fifo_data = head word whenever level > 0; there is no empty-bypass path.
REQ-022 fifo_valid = (level != 0) & out_en.
REQ-023 A push SHALL be accepted when level < DEPTH, or when a pop occurs in the same cycle.
REQ-024 A push that is not accepted SHALL be dropped and SHALL set overflow; the level and contents SHALL be unchanged.
REQ-025 A simultaneous push and pop SHALL leave the level unchanged and preserve word order.
REQ-026 Read and write pointers SHALL be DEPTH_LOG2 bits wide and wrap modulo DEPTH; level SHALL be DEPTH_LOG2+1 bits wide and range 0..DEPTH.
REQ-027 hi_pend SHALL be set on the cycle in which level goes from < HI_WATER to >= HI_WATER.
REQ-028 lo_pend SHALL be set on the cycle in which level goes from > LO_WATER to <= LO_WATER.
REQ-029 When a set and a CLEAR of the same bit coincide, the set SHALL win.
REQ-030 irq = (hi_pend & hi_irq_en) | (lo_pend & lo_irq_en), registered-source with no combinational path from CPU inputs.
REQ-031 STATUS reads SHALL return the register values present at the start of the CPURead cycle.
REQ-032 CPURead and CPUWrite in the same cycle SHALL both be serviced.

Reset
REQ-033 While resetn is low at a clk edge, the following SHALL be cleared to 0: pointers, level, CONTROL, overflow, hi_pend, lo_pend.
REQ-034 During and after reset, fifo_valid = 0 and irq = 0; FIFO contents are discarded and a reset mid-stream drops all queued words.
REQ-035 Storage RAM contents SHALL NOT require reset.

Configuration
REQ-036 Macro CMD_FIFO_IRQ_EN defined: watermark logic, irq, and STATUS bits 19/20 and CONTROL bits 1/2 behave per REQ-027..030.
REQ-037 Macro CMD_FIFO_IRQ_EN undefined: irq tied 0; STATUS bits 19/20 and CONTROL bits 1/2 read 0 and are write-ignored; no watermark logic is synthesized.

Verification
REQ-038 Reset, write CONTROL=0x1, push 0xA5A5_0001..0xA5A5_0003 -> STATUS level=3; consumer with fifo_ready=1 receives the three words in order; STATUS then reads 0x0001_0000.
REQ-039 out_en=0, push 33 words at DEPTH_LOG2=5 -> level=32, full=1, overflow=1, word 33 absent; CLEAR=0x1 -> overflow=0.
REQ-040 Full FIFO with fifo_ready=1 and a push in the same cycle -> push accepted, level stays 32, overflow stays 0, order preserved across pointer wrap.
REQ-041 CONTROL=0x7, fill to 24 -> hi_pend=1 and irq=1; drain to 8 -> lo_pend=1; CLEAR=0x2 in the same cycle as a new 23->24 crossing -> hi_pend remains 1.
REQ-042 resetn low for one cycle with 10 words queued -> level=0, fifo_valid=0, CONTROL=0, irq=0; a read of 0x0010 returns 0.

Source files
------------

// File: rtl/cmd_fifo_iface.sv
// cmd_fifo_iface: CPU-programmable command FIFO with a register interface.
// The CPU pushes 32-bit words through the DATA register. A consumer drains
// them through a valid/ready port that only presents data while out_en is set.
// Optional watermark interrupts are built only when CMD_FIFO_IRQ_EN is defined.
// Without that macro, irq is tied low and the watermark status and control
// bits read as zero.
module cmd_fifo_iface #(
    parameter int DEPTH_LOG2 = 5,
    parameter int HI_WATER   = 24,
    parameter int LO_WATER   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        CPURead,
    input  logic        CPUWrite,
    input  logic [15:0] CPUAddress,
    input  logic [31:0] CPUWriteData,
    output logic [31:0] CPUReadData,
    output logic [31:0] fifo_data,
    output logic        fifo_valid,
    input  logic        fifo_ready,
    output logic        irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [15:0] ADDR_DATA   = 16'h0000;
    localparam logic [15:0] ADDR_STATUS = 16'h0004;
    localparam logic [15:0] ADDR_CTRL   = 16'h0008;
    localparam logic [15:0] ADDR_CLEAR  = 16'h000C;

    logic [31:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LW-1:0]         level;
    logic                  out_en;
    logic                  overflow;

    logic wr_data;
    logic wr_ctrl;
    logic wr_clr;
    logic pop;
    logic push_ok;

    logic st_hi;
    logic st_lo;
    logic ctl_hi;
    logic ctl_lo;

    assign wr_data = CPUWrite && (CPUAddress == ADDR_DATA);
    assign wr_ctrl = CPUWrite && (CPUAddress == ADDR_CTRL);
    assign wr_clr  = CPUWrite && (CPUAddress == ADDR_CLEAR);

    assign fifo_valid = (level != '0) && out_en;
    assign pop        = fifo_valid && fifo_ready;
    // A full FIFO can still take a word when a pop frees a slot in the same cycle.
    assign push_ok    = wr_data && ((level < DEPTH_L) || pop);
    assign fifo_data  = mem[rd_ptr];

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= CPUWriteData;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Output enable and the sticky overflow flag; a new overflow beats a clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                out_en <= CPUWriteData[0];
            end
            if (wr_data && !push_ok) begin
                overflow <= 1'b1;
            end else if (wr_clr && CPUWriteData[0]) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef CMD_FIFO_IRQ_EN
    localparam logic [LW-1:0] HI_L = LW'(HI_WATER);
    localparam logic [LW-1:0] LO_L = LW'(LO_WATER);

    logic [LW-1:0] level_prev;
    logic          hi_en;
    logic          lo_en;
    logic          hi_pend;
    logic          lo_pend;
    logic          hi_set;
    logic          lo_set;

    // A crossing is seen in the cycle the new level is present, which lets a
    // CLEAR issued right after the push that caused it collide with the set.
    assign hi_set = (level_prev < HI_L) && (level >= HI_L);
    assign lo_set = (level_prev > LO_L) && (level <= LO_L);

    // Watermark enables and pending flags; a set beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            level_prev <= '0;
            hi_en      <= 1'b0;
            lo_en      <= 1'b0;
            hi_pend    <= 1'b0;
            lo_pend    <= 1'b0;
        end else begin
            level_prev <= level;
            if (wr_ctrl) begin
                hi_en <= CPUWriteData[1];
                lo_en <= CPUWriteData[2];
            end
            if (hi_set) begin
                hi_pend <= 1'b1;
            end else if (wr_clr && CPUWriteData[1]) begin
                hi_pend <= 1'b0;
            end
            if (lo_set) begin
                lo_pend <= 1'b1;
            end else if (wr_clr && CPUWriteData[2]) begin
                lo_pend <= 1'b0;
            end
        end
    end

    assign irq    = (hi_pend && hi_en) || (lo_pend && lo_en);
    assign st_hi  = hi_pend;
    assign st_lo  = lo_pend;
    assign ctl_hi = hi_en;
    assign ctl_lo = lo_en;
`else
    assign irq    = 1'b0;
    assign st_hi  = 1'b0;
    assign st_lo  = 1'b0;
    assign ctl_hi = 1'b0;
    assign ctl_lo = 1'b0;
`endif

    // Register read mux; reflects register state at the start of the read cycle.
    always_comb begin
        logic [31:0] status;
        status                = '0;
        status[DEPTH_LOG2:0]  = level;
        status[16]            = (level == '0);
        status[17]            = (level == DEPTH_L);
        status[18]            = overflow;
        status[19]            = st_hi;
        status[20]            = st_lo;
        CPUReadData           = '0;
        if (CPURead) begin
            case (CPUAddress)
                ADDR_STATUS: CPUReadData = status;
                ADDR_CTRL:   CPUReadData = {29'd0, ctl_lo, ctl_hi, out_en};
                default:     CPUReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_fifo_iface.sv
// Directed bench for cmd_fifo_iface with a queue-based reference model and
// literal expectations for the key register and stream values.
module tb_cmd_fifo_iface;

    localparam int DEPTH = 32;
    localparam int HI    = 24;
    localparam int LO    = 8;
`ifdef CMD_FIFO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        CPURead = 1'b0;
    logic        CPUWrite = 1'b0;
    logic [15:0] CPUAddress = 16'h0;
    logic [31:0] CPUWriteData = 32'h0;
    logic [31:0] CPUReadData;
    logic [31:0] fifo_data;
    logic        fifo_valid;
    logic        fifo_ready = 1'b0;
    logic        irq;

    always #5 clk = ~clk;

    cmd_fifo_iface dut (
        .clk          (clk),
        .resetn       (resetn),
        .CPURead      (CPURead),
        .CPUWrite     (CPUWrite),
        .CPUAddress   (CPUAddress),
        .CPUWriteData (CPUWriteData),
        .CPUReadData  (CPUReadData),
        .fifo_data    (fifo_data),
        .fifo_valid   (fifo_valid),
        .fifo_ready   (fifo_ready),
        .irq          (irq)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue plus flags, updated from the bus at each edge.
    logic [31:0] mq[$];
    bit m_out_en = 0, m_hi_en = 0, m_lo_en = 0, m_ovf = 0, m_hi = 0, m_lo = 0;
    int m_prev = 0;
    int m_old;
    bit m_pop, m_ovf_set, m_hi_set, m_lo_set;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = 32'h0;
        s[5:0]   = 6'(mq.size());
        s[16]    = (mq.size() == 0);
        s[17]    = (mq.size() == DEPTH);
        s[18]    = m_ovf;
        s[19]    = IRQ_EN && m_hi;
        s[20]    = IRQ_EN && m_lo;
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [15:0] a);
        case (a)
            16'h0004: return m_status();
            16'h0008: return {29'd0, IRQ_EN && m_lo_en, IRQ_EN && m_hi_en, m_out_en};
            default:  return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            mq.delete();
            m_out_en = 0; m_hi_en = 0; m_lo_en = 0;
            m_ovf = 0; m_hi = 0; m_lo = 0; m_prev = 0;
        end else begin
            m_old     = mq.size();
            m_pop     = m_out_en && (m_old > 0) && fifo_ready;
            m_hi_set  = (m_prev < HI) && (m_old >= HI);
            m_lo_set  = (m_prev > LO) && (m_old <= LO);
            m_ovf_set = 0;
            m_prev    = m_old;
            if (m_pop) void'(mq.pop_front());
            if (CPUWrite && CPUAddress == 16'h0000) begin
                if (m_old < DEPTH || m_pop) mq.push_back(CPUWriteData);
                else m_ovf_set = 1;
            end
            if (CPUWrite && CPUAddress == 16'h0008) begin
                m_out_en = CPUWriteData[0];
                m_hi_en  = CPUWriteData[1];
                m_lo_en  = CPUWriteData[2];
            end
            if (CPUWrite && CPUAddress == 16'h000C) begin
                if (CPUWriteData[0]) m_ovf = 0;
                if (CPUWriteData[1]) m_hi = 0;
                if (CPUWriteData[2]) m_lo = 0;
            end
            if (m_ovf_set) m_ovf = 1;
            if (m_hi_set) m_hi = 1;
            if (m_lo_set) m_lo = 1;
        end
    end

    // Per-cycle compare of every meaningful output against the model.
    always @(negedge clk) begin
        if (resetn) begin
            bit ev;
            ev = m_out_en && (mq.size() > 0);
            chk("valid", {31'd0, fifo_valid}, {31'd0, ev});
            if (ev) chk("head", fifo_data, mq[0]);
            chk("irq", {31'd0, irq},
                {31'd0, IRQ_EN && ((m_hi && m_hi_en) || (m_lo && m_lo_en))});
            if (CPURead) chk("rdata", CPUReadData, m_read(CPUAddress));
        end
    end

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        CPUWrite = 1'b1; CPUAddress = a; CPUWriteData = d;
        @(posedge clk); #1;
        CPUWrite = 1'b0;
    endtask

    task automatic rd_lit(input string name, input logic [15:0] a, input logic [31:0] exp);
        CPURead = 1'b1; CPUAddress = a;
        @(negedge clk);
        chk(name, CPUReadData, exp);
        @(posedge clk); #1;
        CPURead = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    logic [31:0] hiw;

    initial begin
        hiw = IRQ_EN ? 32'h0008_0000 : 32'h0;
        resetn = 1'b0;
        idle(2);
        resetn = 1'b1;

        rd_lit("rst_status", 16'h0004, 32'h0001_0000);
        rd_lit("rst_ctrl", 16'h0008, 32'h0);

        // Read and write CONTROL in the same cycle: read sees the old value.
        CPURead = 1'b1; CPUWrite = 1'b1; CPUAddress = 16'h0008; CPUWriteData = 32'h1;
        @(negedge clk);
        chk("rw_same_old", CPUReadData, 32'h0);
        @(posedge clk); #1;
        CPURead = 1'b0; CPUWrite = 1'b0;
        rd_lit("ctrl_after_rw", 16'h0008, 32'h1);

        for (int i = 0; i < 3; i++) wr(16'h0000, 32'hA5A5_0001 + i);
        rd_lit("lvl3_status", 16'h0004, 32'h0000_0003);
        fifo_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stream_valid", {31'd0, fifo_valid}, 32'h1);
            chk("stream_word", fifo_data, 32'hA5A5_0001 + i);
            @(posedge clk); #1;
        end
        fifo_ready = 1'b0;
        rd_lit("drained_status", 16'h0004, 32'h0001_0000);

        // Overfill with the output disabled.
        wr(16'h0008, 32'h0);
        for (int i = 0; i < 33; i++) wr(16'h0000, 32'h0000_1000 + i);
        rd_lit("full_status", 16'h0004, 32'h0006_0020 | hiw);
        wr(16'h000C, 32'h1);
        rd_lit("ovf_cleared", 16'h0004, 32'h0002_0020 | hiw);

        // Push and pop on a full FIFO in the same cycle, then drain across the wrap.
        wr(16'h0008, 32'h1);
        fifo_ready = 1'b1;
        wr(16'h0000, 32'h0000_2000);
        fifo_ready = 1'b0;
        rd_lit("wrap_status", 16'h0004, 32'h0002_0020 | hiw);
        fifo_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("wrap_word", fifo_data, (i < 31) ? 32'h0000_1001 + i : 32'h0000_2000);
            @(posedge clk); #1;
        end
        fifo_ready = 1'b0;
        rd_lit("wrap_drained", 16'h0004, IRQ_EN ? 32'h0019_0000 : 32'h0001_0000);

        // Watermarks.
        wr(16'h000C, 32'h7);
        wr(16'h0008, 32'h7);
        for (int i = 0; i < 24; i++) wr(16'h0000, 32'h0000_3000 + i);
        idle(1);
        chk("hi_irq", {31'd0, irq}, {31'd0, IRQ_EN});
        rd_lit("hi_status", 16'h0004, IRQ_EN ? 32'h0008_0018 : 32'h0000_0018);
        fifo_ready = 1'b1;
        idle(16);
        fifo_ready = 1'b0;
        idle(1);
        rd_lit("lo_status", 16'h0004, IRQ_EN ? 32'h0018_0008 : 32'h0000_0008);
        wr(16'h000C, 32'h2);
        rd_lit("hi_cleared", 16'h0004, IRQ_EN ? 32'h0010_0008 : 32'h0000_0008);
        for (int i = 0; i < 16; i++) wr(16'h0000, 32'h0000_4000 + i);
        wr(16'h000C, 32'h2);
        rd_lit("set_wins", 16'h0004, IRQ_EN ? 32'h0018_0018 : 32'h0000_0018);

        // Reset mid-stream with ten words queued.
        fifo_ready = 1'b1;
        idle(14);
        fifo_ready = 1'b0;
        rd_lit("lvl10_status", 16'h0004, IRQ_EN ? 32'h0018_000A : 32'h0000_000A);
        resetn = 1'b0;
        idle(1);
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {31'd0, fifo_valid}, 32'h0);
        chk("post_rst_irq", {31'd0, irq}, 32'h0);
        @(posedge clk); #1;
        rd_lit("post_rst_status", 16'h0004, 32'h0001_0000);
        rd_lit("post_rst_ctrl", 16'h0008, 32'h0);
        rd_lit("unmapped_rd", 16'h0010, 32'h0);
        wr(16'h0010, 32'hFFFF_FFFF);
        rd_lit("unmapped_wr", 16'h0008, 32'h0);
        rd_lit("data_rd0", 16'h0000, 32'h0);
        rd_lit("clear_rd0", 16'h000C, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
